// File: rtl/xor_sweep_pkg.sv
// Shared types for the XOR operand sweep block.
// State encoding and default operand width.
package xor_sweep_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/xor_pair_counter.sv
// Nested a/b operand counter, b is the minor digit.
// Holds on the last pair until cleared.
module xor_pair_counter
  import xor_sweep_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             last
);

  assign last = (&a) & (&b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
    end else if (clr) begin
      a <= '0;
      b <= '0;
    end else if (en && !last) begin
      b <= b + 1'b1;
      if (&b) a <= a + 1'b1;
    end
  end

endmodule

// File: rtl/xor_operand_sweep.sv
// Sweeps every (a,b) operand pair into a downstream XOR stage.
// Define XOR_CHECK_EN to add result checking and err_cnt.
module xor_operand_sweep
  import xor_sweep_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  localparam int CNT_W = 2*WIDTH+1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ready,
`ifdef XOR_CHECK_EN
  input  logic [WIDTH-1:0] res_out,
  input  logic [WIDTH-1:0] res_out0,
  input  logic [WIDTH-1:0] res_or,
  output logic [CNT_W-1:0] err_cnt,
`endif
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pair_cnt
);

  state_t state;
  state_t state_nxt;
  logic   hs;
  logic   clr;
  logic   last;

  assign hs  = valid && ready;
  assign clr = (state == IDLE) && start;

  xor_pair_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (hs),
    .a    (a),
    .b    (b),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (hs && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state)
      RUN: begin
        valid = 1'b1;
        busy  = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pair_cnt <= '0;
    else if (clr) pair_cnt <= '0;
    else if (hs)  pair_cnt <= pair_cnt + CNT_W'(1);
  end

`ifdef XOR_CHECK_EN
  logic [WIDTH-1:0] x;
  logic             bad;

  assign x   = a ^ b;
  assign bad = (res_out != x) || (res_out0 != ~x) ||
               (res_or != {WIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          err_cnt <= '0;
    else if (clr)        err_cnt <= '0;
    else if (hs && bad)  err_cnt <= err_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: doc/xor_operand_sweep.md
XOR_OPERAND_SWEEP -- requirements
Module: xor_operand_sweep

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits; CNT_W = 2*WIDTH+1 is derived from it.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, sweep request, sampled only in IDLE.
REQ-005 SHALL have port ready, input, 1, downstream XOR stage accepts the current pair.
REQ-006 SHALL have port a, output, WIDTH, first operand to the XOR stage.
REQ-007 SHALL have port b, output, WIDTH, second operand to the XOR stage.
REQ-008 SHALL have port valid, output, 1, a/b hold a pair to be consumed.
REQ-009 SHALL have port busy, output, 1, high in RUN.
REQ-010 SHALL have port done, output, 1, one-cycle pulse in DONE.
REQ-011 SHALL have port pair_cnt, output, CNT_W, pairs handed over since last start.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE, registered state, Moore outputs.
REQ-013 IDLE: valid=0, busy=0; start=1 -> RUN next cycle with a=0, b=0, pair_cnt=0 (and err_cnt=0 when checking is enabled).
REQ-014 RUN: valid=1, busy=1; handshake = valid && ready in the same cycle.
REQ-015 On handshake: pair_cnt += 1; b increments; b wrap 2^WIDTH-1 -> 0 increments a.
REQ-016 On handshake with a=b=2^WIDTH-1: a,b hold, next state DONE.
REQ-017 ready=0 in RUN: a, b, valid, pair_cnt hold unchanged for any number of cycles.
REQ-018 DONE: valid=0, busy=0, done=1 for exactly one cycle, then IDLE; a, b, pair_cnt keep final values (pair_cnt = 2^(2*WIDTH) = 256 for WIDTH=4).
REQ-019 start asserted in RUN or DONE SHALL be ignored.
REQ-020 Order SHALL be a-major, b-minor: (0,0),(0,1)...(0,15),(1,0)...(15,15).

Reset
REQ-021 rst_n=0 SHALL force, asynchronously and at any point including mid-sweep: state=IDLE, a=0, b=0, valid=0, busy=0, done=0, pair_cnt=0, err_cnt=0.
REQ-022 After reset release, the first start SHALL restart the sweep at (0,0).

Configuration
REQ-023 Macro XOR_CHECK_EN SHALL compile in result checking: extra inputs res_out, res_out0, res_or (each WIDTH) and output err_cnt (CNT_W).
REQ-024 With XOR_CHECK_EN, on each handshake the block SHALL compare, same cycle, res_out == a^b, res_out0 == ~(a^b), res_or == all-ones; any mismatch increments err_cnt by exactly 1.
REQ-025 Without XOR_CHECK_EN, those ports and the comparison logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Package xor_sweep_pkg SHALL hold the state enum (IDLE, RUN, DONE) and constant WIDTH_DEFAULT=4.
REQ-027 Sub-module xor_pair_counter SHALL hold the a/b nested counter with increment enable and last-pair flag; the FSM lives in xor_operand_sweep.

Verification
REQ-028 Reset: rst_n=0 -> a=0, b=0, valid=0, busy=0, done=0, pair_cnt=0; then hold start=0 -> outputs stay 0.
REQ-029 Full sweep: start pulse, ready=1 constantly -> 256 consecutive handshakes; pair 17 is (1,0), last is (15,15); done pulses the cycle after the last handshake; pair_cnt=256.
REQ-030 Backpressure: ready=0 for 5 cycles at (3,7) -> a=3, b=7, valid=1, pair_cnt=55 for all 5 cycles; ready=1 -> next pair (3,8).
REQ-031 Ignored start: start pulsed at pair_cnt=40 -> sweep continues unaffected; start during DONE -> back to IDLE, no restart.
REQ-032 Mid-sweep reset: rst_n=0 at pair_cnt=100 -> all outputs 0 immediately; new start -> first pair (0,0).
REQ-033 XOR_CHECK_EN: real XOR stage connected -> err_cnt=0 at done; res_or forced to 4'hE on one handshake -> err_cnt=1 at done.
